// File: rtl/wfifo_src.sv
// Write-domain producer: skid-buffered upstream stream into FIFO write port; optional level/almost-full under WFIFO_SRC_LEVEL_EN.
// Accepted word is presented on wdata_o with wincr_o one cycle later; stalls on wfull_i, s_ready_o drops once the skid stage fills.
module wfifo_src #(
  parameter int DATA_W       = 8,
  parameter int ADDR_LEN     = 8,
  parameter int AFULL_THRESH = 2**ADDR_LEN - 2
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                s_valid_i,
  input  logic [DATA_W-1:0]   s_data_i,
  output logic                s_ready_o,
  input  logic                wfull_i,
  input  logic [ADDR_LEN:0]   wptr_i,
  input  logic [ADDR_LEN:0]   r2wptr_sync_i,
  output logic                wincr_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [ADDR_LEN:0]   wlevel_o,
  output logic                walmost_full_o
);

  logic              out_vld;
  logic [DATA_W-1:0] out_data;
  logic              skid_vld;
  logic [DATA_W-1:0] skid_data;
  logic              commit;
  logic              accept;

  // Ready depends only on skid occupancy, so no combinational path from wfull_i.
  assign s_ready_o = !skid_vld;
  assign wincr_o   = out_vld & !wfull_i;
  assign wdata_o   = out_data;
  assign commit    = wincr_o;
  assign accept    = s_valid_i & s_ready_o;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      out_vld   <= 1'b0;
      out_data  <= '0;
      skid_vld  <= 1'b0;
      skid_data <= '0;
    end else if (!out_vld || commit) begin
      if (skid_vld) begin
        out_vld  <= 1'b1;
        out_data <= skid_data;
        skid_vld <= 1'b0;
      end else if (accept) begin
        out_vld  <= 1'b1;
        out_data <= s_data_i;
      end else begin
        out_vld  <= 1'b0;
      end
    end else if (accept) begin
      skid_vld  <= 1'b1;
      skid_data <= s_data_i;
    end
  end

`ifdef WFIFO_SRC_LEVEL_EN
  localparam int PW = ADDR_LEN + 1;
  localparam logic [PW-1:0] AF_T = PW'(AFULL_THRESH);

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Modulo subtraction keeps the level correct across pointer wrap; stale read pointer only over-reports.
  logic [PW-1:0] level;
  assign level = gray2bin(wptr_i) - gray2bin(r2wptr_sync_i);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wlevel_o       <= '0;
      walmost_full_o <= 1'b0;
    end else begin
      wlevel_o       <= level;
      walmost_full_o <= (level >= AF_T);
    end
  end
`else
  logic unused_ptrs;
  assign unused_ptrs    = ^{wptr_i, r2wptr_sync_i};
  assign wlevel_o       = '0;
  assign walmost_full_o = 1'b0;
`endif

endmodule

// File: doc/wfifo_src.md
# wfifo_src

Write-domain producer for the asynchronous FIFO. Accepts words from an upstream valid/ready stream and drives the write-pointer controller's increment request and the FIFO memory write data, honouring the registered full flag without loss or duplication. Optionally reports a pessimistic fill level and almost-full flag, derived from the Gray write pointer and the synchronized Gray read pointer. Sits in the wclk domain between the upstream producer and the write-pointer controller / dual-port memory.

## Interface

- DATA_W, 8, width of a FIFO word
- ADDR_LEN, 8, FIFO address width; depth = 2^ADDR_LEN; pointers are ADDR_LEN+1 bits
- AFULL_THRESH, 2^ADDR_LEN-2, level at or above which walmost_full_o asserts; legal range 1..2^ADDR_LEN
- wclk  input  1  write clock; all state on its rising edge
- wrst_n  input  1  reset, asynchronous, active-low
- s_valid_i  input  1  upstream word valid
- s_data_i  input  DATA_W  upstream word
- s_ready_o  output  1  block can take a word this cycle
- wfull_i  input  1  registered full flag from write-pointer controller
- wptr_i  input  ADDR_LEN+1  Gray write pointer from write-pointer controller
- r2wptr_sync_i  input  ADDR_LEN+1  Gray read pointer synchronized into wclk
- wincr_o  output  1  write request to write-pointer controller and memory write enable
- wdata_o  output  DATA_W  memory write data, valid while wincr_o=1
- wlevel_o  output  ADDR_LEN+1  registered fill level, 0..2^ADDR_LEN
- walmost_full_o  output  1  registered, wlevel >= AFULL_THRESH

## Operation

- Two registers: output stage (out_vld, out_data) and skid stage (skid_vld, skid_data).
- Upstream handshake: a word transfers on a rising edge where s_valid_i=1 and s_ready_o=1. s_ready_o = !skid_vld (registered state, no combinational path from wfull_i or s_valid_i).
- wincr_o = out_vld & !wfull_i; wdata_o = out_data. A write commits on an edge where wincr_o=1.
- Per edge, with commit = wincr_o and accept = s_valid_i & s_ready_o:
  - out stage empty, or commit: load from skid if skid_vld (skid clears), else from s_data_i if accept, else out_vld<=0.
  - out stage full, no commit, accept: word goes to skid (skid_vld<=1).
  - Simultaneous commit and accept with skid_vld=1 cannot occur (s_ready_o=0).
- Words reach wdata_o in strict arrival order; none dropped or repeated.
- Level path: Gray-to-binary conversion of wptr_i and r2wptr_sync_i (MSB-first XOR prefix). level = (wbin - rbin) mod 2^(ADDR_LEN+1), registered into wlevel_o. walmost_full_o registered from level >= AFULL_THRESH, computed from the same unregistered level.
- Level is pessimistic (read pointer stale by synchronizer latency); it never under-reports occupancy relative to the pointers presented.
- wfull_i is authoritative for writes; walmost_full_o is advisory only.

## Timing

- Reset values: out_vld=0, skid_vld=0, so s_ready_o=1, wincr_o=0; out_data/skid_data/wdata_o=0; wlevel_o=0; walmost_full_o=0. Upstream must hold s_valid_i=0 while wrst_n=0.
- Reset mid-operation: buffered words (up to 2) are discarded; outputs return to reset values asynchronously.
- Latency: word accepted at edge k appears on wdata_o with wincr_o=1 in cycle k+1 (if wfull_i=0); committed at edge k+1.
- Throughput: one word per cycle while wfull_i=0.
- Full: when wfull_i rises, wincr_o drops in the same cycle; out stage holds. One further upstream word may be taken into skid; s_ready_o drops the cycle after.
- Full release: wincr_o reasserts in the first cycle wfull_i=0; s_ready_o returns the cycle after the skid drains.
- Wrap-around: pointer subtraction is modulo 2^(ADDR_LEN+1); level correct across pointer wrap. Level = 2^ADDR_LEN exactly when full.
- wlevel_o/walmost_full_o lag pointer inputs by one cycle.

## Configuration

- WFIFO_SRC_LEVEL_EN defined: Gray-to-binary, subtraction and level/almost-full registers compiled in as above.
- Not defined: level logic absent; wlevel_o and walmost_full_o tied to 0; ports unchanged; data path unaffected.

## Test plan

Configuration: DATA_W=8, ADDR_LEN=3, AFULL_THRESH=6, WFIFO_SRC_LEVEL_EN defined, model of write-pointer controller attached.
- Reset release, s_valid_i=0 -> s_ready_o=1, wincr_o=0, wlevel_o=0, walmost_full_o=0.
- Stream 0x01..0x05 back-to-back, reader idle -> wincr_o high cycles 1..5 after first accept, wdata_o 0x01..0x05 in order, wlevel_o reaches 5.
- Stream 0x10..0x1A, reader idle -> 8 writes commit (0x10..0x17), wfull_i=1, wincr_o=0, 0x18 held in out stage, 0x19 in skid, s_ready_o=0, wlevel_o=8, walmost_full_o=1 from level 6.
- From the full state, read pointer advances by 3 -> 0x18, 0x19, 0x1A commit in order, no duplicates, s_ready_o returns to 1.
- Pointers driven to wbin=0x2 (after wrap), rbin=0xE -> wlevel_o=4, walmost_full_o=0.
- Assert wrst_n=0 with both stages full -> outputs immediately at reset values; after release the next word streamed is the first written.
